// File: rtl/result_classifier_pkg.sv
// Shared types and default sizing for the result classifier.
package result_classifier_pkg;

  localparam int DEFAULT_NUM_CLASSES = 10;
  localparam int DEFAULT_DATA_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/result_classifier_max_tracker.sv
// Running arg-max over sampled results; ties keep the lower index.
module result_classifier_max_tracker
  import result_classifier_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic              sample_first,
  input  logic [3:0]        sample_idx,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] best_value,
  output logic [3:0]        best_idx,
  output logic              saturated
);

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic is_sat;
  logic is_better;

  assign is_sat    = (sample_data == MAX_POS) || (sample_data == MAX_NEG);
  assign is_better = $signed(sample_data) > $signed(best_value);

  // Strict greater-than means an equal later value never displaces the earlier index.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_value <= '0;
      best_idx   <= '0;
      saturated  <= 1'b0;
    end else if (sample_valid) begin
      if (sample_first || is_better) begin
        best_value <= sample_data;
        best_idx   <= sample_idx;
      end
      saturated <= saturated | is_sat;
    end
  end

endmodule

// File: rtl/result_classifier.sv
// Scans NUM_CLASSES result registers and reports the index of the largest signed value.
module result_classifier
  import result_classifier_pkg::*;
#(
  parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
  parameter int DATA_W      = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_classify,
  input  logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_sel,
  output logic              busy,
  output logic              class_valid,
  output logic [3:0]        class_idx,
  output logic [DATA_W-1:0] max_value,
  output logic              saturated
);

  state_t      state;
  state_t      next_state;
  logic [4:0]  issue_cnt;
  logic        issuing;
  logic        sample_valid;
  logic [3:0]  sample_idx;
  logic        accept_start;
  logic        last_sample;

  assign accept_start = start_classify && (state != SCAN);
  assign issuing      = (state == SCAN) && (issue_cnt < 5'(NUM_CLASSES));
  assign last_sample  = sample_valid && (sample_idx == 4'(NUM_CLASSES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // SCAN lasts one cycle past the last index so the final read-back is sampled.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_classify) next_state = SCAN;
      SCAN:    if (last_sample)    next_state = DONE;
      DONE:    if (start_classify) next_state = SCAN;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == SCAN);
    class_valid = (state == DONE);
    out_sel     = issuing ? issue_cnt[3:0] : 4'd0;
  end

  // The read-back arrives one cycle after its index, so the index is delayed alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt    <= '0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
    end else begin
      if (accept_start) begin
        issue_cnt <= '0;
      end else if (issuing) begin
        issue_cnt <= issue_cnt + 5'd1;
      end
      sample_valid <= issuing;
      sample_idx   <= out_sel;
    end
  end

  result_classifier_max_tracker #(
    .DATA_W(DATA_W)
  ) u_max_tracker (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept_start),
    .sample_valid (sample_valid),
    .sample_first (sample_idx == 4'd0),
    .sample_idx   (sample_idx),
    .sample_data  (out_data),
    .best_value   (max_value),
    .best_idx     (class_idx),
    .saturated    (saturated)
  );

endmodule

// File: tb/tb_result_classifier.sv
// Scoreboard bench: result register bank model, expected results queued at start, popped on class_valid.
module tb_result_classifier;

  localparam int N = 10;
  localparam int W = 16;

  typedef logic [W-1:0] set_t [N];
  typedef struct packed {
    logic [3:0]   idx;
    logic [W-1:0] val;
    logic         sat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_classify;
  logic [W-1:0] out_data;
  logic [3:0]   out_sel;
  logic         busy;
  logic         class_valid;
  logic [3:0]   class_idx;
  logic [W-1:0] max_value;
  logic         saturated;

  logic [W-1:0] mem [16];
  exp_t         sb [$];
  int           checks = 0;
  int           errors = 0;

  result_classifier #(
    .NUM_CLASSES(N),
    .DATA_W(W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_classify (start_classify),
    .out_data       (out_data),
    .out_sel        (out_sel),
    .busy           (busy),
    .class_valid    (class_valid),
    .class_idx      (class_idx),
    .max_value      (max_value),
    .saturated      (saturated)
  );

  always #5 clk = ~clk;

  // Result register bank: registered read, valid one cycle after out_sel.
  always @(posedge clk) out_data <= mem[out_sel];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input set_t s);
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < N; i++) mem[i] = s[i];
  endtask

  function automatic exp_t model();
    exp_t e;
    e.idx = 4'd0;
    e.val = mem[0];
    e.sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0 && $signed(mem[i]) > $signed(e.val)) begin
        e.val = mem[i];
        e.idx = 4'(i);
      end
      if (mem[i] == 16'h7FFF || mem[i] == 16'h8000) e.sat = 1'b1;
    end
    return e;
  endfunction

  task automatic check_zero(input string name);
    checks++;
    if (out_sel !== 4'd0 || busy !== 1'b0 || class_valid !== 1'b0 ||
        class_idx !== 4'd0 || max_value !== '0 || saturated !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: got sel=%0d busy=%b valid=%b idx=%0d max=%h sat=%b, expected all zero",
               name, out_sel, busy, class_valid, class_idx, max_value, saturated);
    end
  endtask

  task automatic run_scan(input string name, input bit repulse);
    exp_t e;
    bit   seen;
    logic [3:0] held_idx;
    sb.push_back(model());
    start_classify = 1'b1;
    tick();
    start_classify = 1'b0;
    for (int k = 1; k <= N + 1; k++) begin
      checks++;
      if (busy !== 1'b1 || class_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s scan_flags k=%0d: got busy=%b valid=%b, expected busy=1 valid=0",
                 name, k, busy, class_valid);
      end
      if (k <= N) begin
        checks++;
        if (out_sel !== 4'(k - 1)) begin
          errors++;
          $display("[TB] FAIL %s out_sel k=%0d: got %0d expected %0d", name, k, out_sel, k - 1);
        end
      end
      start_classify = (repulse && k == 4);
      tick();
    end
    start_classify = 1'b0;
    checks++;
    if (class_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s latency: class_valid=%b at start+%0d, expected 1", name, class_valid, N + 2);
    end
    seen = (class_valid === 1'b1);
    for (int w = 0; w < 8 && !seen; w++) begin
      tick();
      seen = (class_valid === 1'b1);
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: class_valid never rose, expected idx=%0d", name, e.idx);
      return;
    end
    checks++;
    if (class_idx !== e.idx) begin
      errors++;
      $display("[TB] FAIL %s class_idx: got %0d expected %0d", name, class_idx, e.idx);
    end
    checks++;
    if (max_value !== e.val) begin
      errors++;
      $display("[TB] FAIL %s max_value: got %h expected %h", name, max_value, e.val);
    end
    checks++;
    if (saturated !== e.sat) begin
      errors++;
      $display("[TB] FAIL %s saturated: got %b expected %b", name, saturated, e.sat);
    end
    held_idx = e.idx;
    for (int h = 0; h < 3; h++) begin
      tick();
      checks++;
      if (class_valid !== 1'b1 || busy !== 1'b0 || out_sel !== 4'd0 ||
          class_idx !== held_idx || max_value !== e.val || saturated !== e.sat) begin
        errors++;
        $display("[TB] FAIL %s hold h=%0d: got valid=%b busy=%b sel=%0d idx=%0d max=%h sat=%b, expected 1 0 0 %0d %h %b",
                 name, h, class_valid, busy, out_sel, class_idx, max_value, saturated, held_idx, e.val, e.sat);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_classify = 1'b0;
    tick();
    tick();
    check_zero("reset_asserted");
    rst = 1'b0;
    tick();
    check_zero("reset_released");
  endtask

  task automatic test_basic();
    load('{16'd5, 16'd9, 16'(-3), 16'd100, 16'd2, 16'd7, 16'd0, 16'd1, 16'd8, 16'd4});
    run_scan("basic", 1'b0);
  endtask

  task automatic test_ties();
    load('{default: 16'h0042});
    run_scan("ties", 1'b0);
  endtask

  task automatic test_negative();
    load('{16'(-10), 16'(-2), 16'(-7), 16'(-20), 16'(-15), 16'(-30), 16'(-5), 16'(-40), 16'(-25), 16'(-50)});
    run_scan("negative", 1'b0);
  endtask

  task automatic test_saturation();
    load('{16'(-10), 16'(-2), 16'(-7), 16'(-20), 16'(-15), 16'(-30), 16'(-5), 16'(-40), 16'(-25), 16'h7FFF});
    run_scan("sat_pos", 1'b0);
    load('{16'd5, 16'd9, 16'(-3), 16'd100, 16'h8000, 16'd7, 16'd0, 16'd1, 16'd8, 16'd4});
    run_scan("sat_neg", 1'b0);
  endtask

  task automatic test_restart_ignored();
    load('{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3});
    run_scan("restart_ignored", 1'b1);
  endtask

  task automatic test_back_to_back();
    load('{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10});
    run_scan("b2b_first", 1'b0);
    load('{16'd50, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd80, 16'd9, 16'd10});
    run_scan("b2b_second", 1'b0);
  endtask

  task automatic test_reset_abort();
    load('{16'd5, 16'd9, 16'(-3), 16'd100, 16'd2, 16'd7, 16'd0, 16'd1, 16'd8, 16'd4});
    start_classify = 1'b1;
    tick();
    start_classify = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("abort_reset");
    for (int k = 0; k < N + 4; k++) begin
      tick();
      checks++;
      if (class_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_idle k=%0d: got valid=%b busy=%b expected 0 0", k, class_valid, busy);
      end
    end
    load('{16'd7, 16'd7, 16'd12, 16'd3, 16'd12, 16'd0, 16'd1, 16'd2, 16'd11, 16'd4});
    run_scan("after_abort", 1'b0);
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    start_classify = 1'b1;
    tick();
    rst = 1'b0;
    start_classify = 1'b0;
    check_zero("rst_over_start");
    tick();
    check_zero("rst_over_start_idle");
  endtask

  initial begin
    rst = 1'b1;
    start_classify = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_ties();
    test_negative();
    test_saturation();
    test_restart_ignored();
    test_back_to_back();
    test_reset_abort();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
